latent_reparam_sampler: RTL and testbench

Downstream stage of `encoder_fixed_point`: takes its flattened `M_output`-lane result, interprets the lower half as latent means (mu) and the upper half as standard deviations (sigma), and produces the sampled latent vector z_i = mu_i + sigma_i * eps_i. The noise eps_i comes from an internal 32-bit LFSR. A single shared multiplier is time-multiplexed across lanes under an FSM. Valid/ready handshakes on both sides decouple the block from the encoder and from the decoder.

---
 rtl/latent_reparam_sampler.sv | 136 +++++++++++++
 tb/tb_latent_reparam_sampler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/latent_reparam_sampler.sv
// Reparameterisation stage: z_i = sat(mu_i + sigma_i * eps_i), with eps drawn from a
// 32-bit Galois LFSR and one shared multiplier stepped across the latent lanes.
module latent_reparam_sampler #(
    parameter int unsigned M_output     = 4,
    parameter int unsigned LATENT       = M_output / 2,
    parameter int unsigned BITSIZE      = 32,
    parameter int unsigned FRAC         = 16,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE1ACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [M_output*BITSIZE-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 seed,
    input  logic                        seed_load,
    output logic [LATENT*BITSIZE-1:0]   z,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int unsigned IDX_W     = (LATENT > 1) ? $clog2(LATENT) : 1;
    localparam int unsigned PW        = BITSIZE + FRAC + 1;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_lfsr;
    logic [BITSIZE-1:0] r_prod;
    logic [BITSIZE-1:0] r_mu    [LATENT];
    logic [BITSIZE-1:0] r_sigma [LATENT];
    logic [BITSIZE-1:0] r_z     [LATENT];

    logic [BITSIZE-1:0] w_mu;
    logic [BITSIZE-1:0] w_sigma;
    logic signed [PW-1:0] w_sigma_ext;
    logic signed [PW-1:0] w_eps_ext;
    logic signed [PW-1:0] w_prod_full;
    logic [BITSIZE-1:0] w_prod_q;
    logic               w_unused_prod;
    logic [BITSIZE:0]   w_sum;
    logic [BITSIZE-1:0] w_sat;
    logic [31:0]        w_lfsr_next;
    logic               w_last;

    assign w_mu    = r_mu[r_idx];
    assign w_sigma = r_sigma[r_idx];

    // eps is LFSR[FRAC:0] read as a signed fraction in [-1, 1)
    assign w_sigma_ext = $signed({{(FRAC + 1){w_sigma[BITSIZE-1]}}, w_sigma});
    assign w_eps_ext   = $signed({{BITSIZE{r_lfsr[FRAC]}}, r_lfsr[FRAC:0]});
    assign w_prod_full = w_sigma_ext * w_eps_ext;

    // Dropping the low FRAC bits of a two's-complement product is a floor shift
    assign w_prod_q      = w_prod_full[FRAC +: BITSIZE];
    assign w_unused_prod = ^{w_prod_full[FRAC-1:0], w_prod_full[PW-1]};

    assign w_sum = {w_mu[BITSIZE-1], w_mu} + {r_prod[BITSIZE-1], r_prod};

    always_comb begin
        w_sat = w_sum[BITSIZE-1:0];
        if (w_sum[BITSIZE] != w_sum[BITSIZE-1]) begin
            w_sat = w_sum[BITSIZE] ? {1'b1, {(BITSIZE-1){1'b0}}}
                                   : {1'b0, {(BITSIZE-1){1'b1}}};
        end
    end

    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
    assign w_last      = (r_idx == IDX_W'(LATENT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_lfsr  <= DEFAULT_SEED;
            r_prod  <= '0;
            for (int unsigned k = 0; k < LATENT; k++) begin
                r_mu[k]    <= '0;
                r_sigma[k] <= '0;
                r_z[k]     <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Seed lands on the same edge as capture, so lane 0 already uses it
                    if (seed_load) begin
                        r_lfsr <= (seed == 32'h0) ? DEFAULT_SEED : seed;
                    end
                    if (in_valid) begin
                        for (int unsigned k = 0; k < LATENT; k++) begin
                            r_mu[k]    <= in_data[k*BITSIZE +: BITSIZE];
                            r_sigma[k] <= in_data[(LATENT+k)*BITSIZE +: BITSIZE];
                        end
                        r_idx   <= '0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod  <= w_prod_q;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_z[r_idx] <= w_sat;
                    r_lfsr     <= w_lfsr_next;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LATENT; g++) begin : g_pack_z
        assign z[g*BITSIZE +: BITSIZE] = r_z[g];
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_latent_reparam_sampler.sv
// Directed and randomized bench for latent_reparam_sampler against an arithmetic
// reference of the reparameterisation rule and the LFSR recurrence.
module tb_latent_reparam_sampler;

    localparam logic [31:0] DEF_SEED = 32'hACE1ACE1;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  seed;
    logic         seed_load;
    logic [63:0]  z;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_lfsr;

    latent_reparam_sampler #(
        .M_output    (4),
        .BITSIZE     (32),
        .FRAC        (16),
        .DEFAULT_SEED(DEF_SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .seed     (seed),
        .seed_load(seed_load),
        .z        (z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // z = clamp(mu + trunc32(floor(sigma * eps / 2^16))), eps = signed 17-bit LFSR slice
    function automatic logic [31:0] ref_lane(input logic [31:0] mu, input logic [31:0] sigma,
                                             input logic [31:0] s);
        longint eps, p, q, t, sum;
        logic [63:0] qb;
        eps = longint'(s[16:0]);
        if (s[16]) eps = eps - 131072;
        p   = longint'($signed(sigma)) * eps;
        q   = p >>> 16;
        qb  = q;
        t   = longint'($signed(qb[31:0]));
        sum = longint'($signed(mu)) + t;
        if (sum > 64'sd2147483647)  sum = 64'sd2147483647;
        if (sum < -64'sd2147483648) sum = -64'sd2147483648;
        return sum[31:0];
    endfunction

    // Runs one transaction from IDLE (at a negedge); returns the DUT z lanes.
    task automatic run_txn(input string tag, input logic [31:0] mu0, input logic [31:0] mu1,
                           input logic [31:0] sg0, input logic [31:0] sg1,
                           input bit ld, input logic [31:0] sd, input bit noisy_seed,
                           input int hold, output logic [31:0] zo0, output logic [31:0] zo1);
        logic [31:0] e0, e1;
        logic [63:0] zheld;
        int cyc;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_data   = {sg1, sg0, mu1, mu0};
        in_valid  = 1'b1;
        seed_load = ld;
        seed      = sd;
        if (ld) m_lfsr = (sd == 32'h0) ? DEF_SEED : sd;
        e0 = ref_lane(mu0, sg0, m_lfsr);
        m_lfsr = lfsr_step(m_lfsr);
        e1 = ref_lane(mu1, sg1, m_lfsr);
        m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
        in_valid  = 1'b0;
        seed_load = noisy_seed;
        seed      = $urandom | 32'h1;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        seed_load = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd5);
        check({tag, "_z0"}, 64'(z[31:0]), 64'(e0));
        check({tag, "_z1"}, 64'(z[63:32]), 64'(e1));
        zheld = z;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check({tag, "_hold_z"}, z, zheld);
            check({tag, "_hold_ov"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_ir"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ret_ir"}, 64'(in_ready), 64'd1);
        check({tag, "_ret_busy"}, 64'(busy), 64'd0);
        zo0 = zheld[31:0];
        zo1 = zheld[63:32];
    endtask

    initial begin
        logic [31:0] r0, r1;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; seed = '0; seed_load = 1'b0; out_ready = 1'b0;
        m_lfsr = DEF_SEED;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_z", z, 64'd0);

        run_txn("zsig", 32'h00010000, 32'hFFFF8000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0, r0, r1);
        check("zsig_z0_const", 64'(r0), 64'h00010000);
        check("zsig_z1_const", 64'(r1), 64'hFFFF8000);

        run_txn("det", 32'h0, 32'h0, 32'h00010000, 32'h00010000, 1'b1, 32'h1, 1'b0, 0, r0, r1);
        check("det_z0_const", 64'(r0), 64'h1);
        check("det_z1_const", 64'(r1), 64'h3);

        run_txn("satp", 32'h7FFFFFFF, $urandom, 32'h00010000, $urandom, 1'b1, 32'h1, 1'b0, 0, r0, r1);
        check("satp_z0_const", 64'(r0), 64'h7FFFFFFF);
        run_txn("satn", 32'h80000000, $urandom, 32'hFFFF0000, $urandom, 1'b1, 32'h1, 1'b0, 0, r0, r1);
        check("satn_z0_const", 64'(r0), 64'h80000000);

        for (int n = 0; n < 10; n++) begin
            logic [31:0] sd;
            sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            run_txn("rand", $urandom, $urandom, $urandom >> $urandom_range(0, 16),
                    $urandom, 1'($urandom_range(0, 1)), sd, 1'b0, 0, r0, r1);
        end

        run_txn("bp", $urandom, $urandom, $urandom, $urandom, 1'b0, 32'h0, 1'b0, 10, r0, r1);

        run_txn("mulseed", $urandom, $urandom, $urandom, $urandom, 1'b0, 32'h0, 1'b1, 0, r0, r1);

        seed_load = 1'b1; seed = 32'h0;
        m_lfsr = DEF_SEED;
        @(negedge clk);
        seed_load = 1'b0;
        run_txn("seed0", $urandom, $urandom, 32'h00012345, 32'hFFF54321, 1'b0, 32'h0, 1'b0, 0, r0, r1);

        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = DEF_SEED;
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_z", z, 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        run_txn("post", 32'h00010000, 32'hFFFF8000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0, r0, r1);
        check("post_z0_const", 64'(r0), 64'h00010000);
        check("post_z1_const", 64'(r1), 64'hFFFF8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
